// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 Pmod keypad scanner.
// Map bit index is 4*col+row throughout.
package keypad_pkg;

    typedef enum logic {SCAN, EVAL} scan_state_t;

    localparam int NUM_COLS = 4;
    localparam int NUM_ROWS = 4;
    localparam int MAP_W    = NUM_COLS * NUM_ROWS;

    function automatic logic [3:0] key_lut(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:  code = 4'h1;
            4'd1:  code = 4'h4;
            4'd2:  code = 4'h7;
            4'd3:  code = 4'h0;
            4'd4:  code = 4'h2;
            4'd5:  code = 4'h5;
            4'd6:  code = 4'h8;
            4'd7:  code = 4'hF;
            4'd8:  code = 4'h3;
            4'd9:  code = 4'h6;
            4'd10: code = 4'h9;
            4'd11: code = 4'hE;
            4'd12: code = 4'hA;
            4'd13: code = 4'hB;
            4'd14: code = 4'hC;
            4'd15: code = 4'hD;
        endcase
        return code;
    endfunction

    function automatic logic [4:0] popcount16(input logic [15:0] map);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < 16; i++) begin
            cnt = cnt + {4'd0, map[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// Frame-level debounce: a key map is accepted only after it has been
// seen unchanged for DEBOUNCE_FRAMES consecutive frame comparisons.
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic             clock_100Mhz,
    input  logic             reset,
    input  logic             sample,
    input  logic [1:0]       col,
    input  logic [3:0]       rows,
    input  logic             eval,
    output logic [MAP_W-1:0] map,
    output logic [MAP_W-1:0] map_next,
    output logic             accept
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] FULL = CW'(DEBOUNCE_FRAMES);

    logic [MAP_W-1:0] raw_map;
    logic [MAP_W-1:0] prev_map;
    logic [CW-1:0]    stable;
    logic [CW-1:0]    stable_next;

    always_comb begin
        stable_next = stable;
        if (raw_map != prev_map) begin
            stable_next = '0;
        end else if (stable != FULL) begin
            stable_next = stable + 1'b1;
        end
        accept   = eval && (stable_next == FULL);
        map_next = accept ? raw_map : map;
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            raw_map  <= '0;
            prev_map <= '0;
            map      <= '0;
            stable   <= '0;
        end else begin
            if (sample) begin
                raw_map[{col, 2'b00} +: 4] <= rows;
            end
            if (eval) begin
                stable   <= stable_next;
                prev_map <= raw_map;
                map      <= map_next;
            end
        end
    end

endmodule

// File: rtl/pmod_keypad_scanner.sv
// Column-multiplexed 4x4 keypad scanner with frame debounce, one-cycle
// key events and a four-digit history word for the display block.
module pmod_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS      = 100000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clock_100Mhz,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic        key_multi,
    output logic [15:0] digits
);

    localparam int DW = $clog2(SCAN_TICKS);
    localparam logic [DW-1:0] LAST = DW'(SCAN_TICKS - 1);
    localparam logic [1:0] LAST_COL = 2'(NUM_COLS - 1);

    scan_state_t state, state_next;
    logic [1:0]  col, col_next;
    logic [DW-1:0] dwell, dwell_next;
    logic        sample, eval;

    logic [3:0] row_meta, row_sync;
    logic [MAP_W-1:0] map, map_next;
    logic       accept;
    logic [4:0] new_pc, old_pc;
    logic [3:0] hit_idx, hit_code;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            state <= SCAN;
            col   <= '0;
            dwell <= '0;
        end else begin
            state <= state_next;
            col   <= col_next;
            dwell <= dwell_next;
        end
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        dwell_next = dwell;
        sample     = 1'b0;
        eval       = 1'b0;
        col_n      = 4'b1111;
        unique case (state)
            SCAN: begin
                col_n = ~(4'b0001 << col);
                if (dwell == LAST) begin
                    sample     = 1'b1;
                    dwell_next = '0;
                    col_next   = col + 2'd1;
                    if (col == LAST_COL) begin
                        state_next = EVAL;
                    end
                end else begin
                    dwell_next = dwell + 1'b1;
                end
            end
            EVAL: begin
                eval       = 1'b1;
                col_next   = '0;
                state_next = SCAN;
            end
        endcase
    end

    keypad_frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_debounce (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .sample      (sample),
        .col         (col),
        .rows        (~row_sync),
        .eval        (eval),
        .map         (map),
        .map_next    (map_next),
        .accept      (accept)
    );

    // The accept strobe only matters through map_next; events compare maps.
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < MAP_W; i++) begin
            if (map_next[i]) hit_idx = 4'(i);
        end
        hit_code = key_lut(hit_idx);
        new_pc   = popcount16(map_next);
        old_pc   = popcount16(map);
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            key_valid <= 1'b0;
            key_code  <= '0;
            key_held  <= 1'b0;
            key_multi <= 1'b0;
            digits    <= '0;
        end else begin
            key_valid <= 1'b0;
            if (eval) begin
                key_held  <= (new_pc == 5'd1);
                key_multi <= (new_pc >= 5'd2);
                if (accept && new_pc == 5'd1 && old_pc == 5'd0) begin
                    key_valid <= 1'b1;
                    key_code  <= hit_code;
                    digits    <= {digits[11:0], hit_code};
                end
            end
        end
    end

endmodule

// File: tb/tb_pmod_keypad_scanner.sv
// Randomised keypad bench with a frame-timeline reference model.
// Keys are a 16-bit set indexed 4*col+row.
module tb_pmod_keypad_scanner;

    localparam int ST    = 8;
    localparam int DF    = 2;
    localparam int FRAME = 4 * ST + 1;

    logic        clock_100Mhz = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic        key_multi;
    logic [15:0] digits;

    logic [15:0] keys = '0;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] code_tbl [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    int          e;
    int          m_stable;
    logic [15:0] m_raw, m_prev, m_deb;
    logic [3:0]  exp_col;
    logic        exp_valid, exp_held, exp_multi;
    logic [3:0]  exp_code;
    logic [15:0] exp_digits;
    logic [3:0]  got[$];

    pmod_keypad_scanner #(
        .SCAN_TICKS     (ST),
        .DEBOUNCE_FRAMES(DF)
    ) dut (
        .clock_100Mhz(clock_100Mhz),
        .reset       (reset),
        .row_n       (row_n),
        .col_n       (col_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_held    (key_held),
        .key_multi   (key_multi),
        .digits      (digits)
    );

    always #5 clock_100Mhz = ~clock_100Mhz;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*c+r] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got_v,
                         input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got_v,
                     exp_v, $time);
        end
    endtask

    function automatic logic [3:0] col_for(input int pos);
        if (pos == 4 * ST) return 4'b1111;
        return ~(4'b0001 << (pos / ST));
    endfunction

    // One clock edge of the reference timeline.
    task automatic model_edge();
        int pos;
        logic [15:0] old;
        exp_valid = 1'b0;
        if (reset) begin
            e = 0;
            m_stable = 0;
            m_raw = '0;
            m_prev = '0;
            m_deb = '0;
            exp_held = 1'b0;
            exp_multi = 1'b0;
            exp_code = '0;
            exp_digits = '0;
        end else begin
            pos = e % FRAME;
            // rows reach the sampler two edges after the keypad
            for (int c = 0; c < 4; c++) begin
                if (pos == c * ST + ST - 1 - 2) m_raw[4*c +: 4] = keys[4*c +: 4];
            end
            if (pos == FRAME - 1) begin
                if (m_raw == m_prev) m_stable = (m_stable + 1 > DF) ? DF : m_stable + 1;
                else m_stable = 0;
                m_prev = m_raw;
                old = m_deb;
                if (m_stable == DF) m_deb = m_raw;
                exp_held  = ($countones(m_deb) == 1);
                exp_multi = ($countones(m_deb) >= 2);
                if ($countones(m_deb) == 1 && $countones(old) == 0) begin
                    exp_valid = 1'b1;
                    for (int i = 0; i < 16; i++) begin
                        if (m_deb[i]) exp_code = code_tbl[i % 4][i / 4];
                    end
                    exp_digits = {exp_digits[11:0], exp_code};
                end
            end
            e++;
        end
        exp_col = col_for(e % FRAME);
    endtask

    task automatic tick();
        @(posedge clock_100Mhz);
        model_edge();
        #1;
        check("cycle", {col_n, key_valid, key_code, key_held, key_multi, digits},
              {exp_col, exp_valid, exp_code, exp_held, exp_multi, exp_digits});
        if (key_valid) got.push_back(key_code);
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) tick();
    endtask

    task automatic align(input int pos);
        while (e % FRAME != pos) tick();
    endtask

    initial begin
        int idx_tbl[4];
        logic [3:0] code_exp[4];
        idx_tbl  = '{2, 12, 3, 8};
        code_exp = '{4'h7, 4'hA, 4'h0, 4'h3};

        reset = 1'b1;
        keys = '0;
        repeat (3) tick();
        check("reset_col", col_n, 4'b1110);
        check("reset_out", {key_valid, key_code, key_held, key_multi, digits}, '0);
        reset = 1'b0;

        for (int k = 1; k <= FRAME; k++) begin
            tick();
            if (k == 8)  check("col1", col_n, 4'b1101);
            if (k == 16) check("col2", col_n, 4'b1011);
            if (k == 24) check("col3", col_n, 4'b0111);
            if (k == 32) check("col_eval", col_n, 4'b1111);
            if (k == 33) check("col_wrap", col_n, 4'b1110);
        end
        frames(2);

        got.delete();
        keys = 16'h0001 << 5;
        frames(6);
        check("p5_count", got.size(), 1);
        if (got.size() > 0) check("p5_code", got[0], 4'h5);
        check("p5_digits", digits, 16'h0005);
        check("p5_held", key_held, 1'b1);

        got.delete();
        for (int k = 0; k < 4; k++) begin
            keys = '0;
            frames(4);
            keys = 16'h0001 << idx_tbl[k];
            frames(5);
        end
        check("seq_count", got.size(), 4);
        for (int k = 0; k < 4 && k < got.size(); k++) check("seq_code", got[k], code_exp[k]);
        check("seq_digits", digits, 16'h7A03);

        keys = '0;
        frames(4);
        align(11);
        got.delete();
        for (int t = 0; t < 4 * FRAME; t++) begin
            keys = ((t / 20) % 2 == 0) ? (16'h0001 << 10) : 16'h0000;
            tick();
        end
        check("bounce_quiet", got.size(), 0);
        keys = 16'h0001 << 10;
        frames(4);
        check("bounce_count", got.size(), 1);
        if (got.size() > 0) check("bounce_code", got[0], 4'h9);

        keys = '0;
        frames(4);
        align(0);
        got.delete();
        keys = 16'h8001;
        frames(5);
        check("multi_flag", key_multi, 1'b1);
        check("multi_held", key_held, 1'b0);
        keys = 16'h0001;
        frames(5);
        check("multi_to_single_held", key_held, 1'b1);
        check("multi_to_single_multi", key_multi, 1'b0);
        check("multi_no_event", got.size(), 0);

        // random idle gap before the reset scenario
        keys = '0;
        frames(3 + int'($urandom_range(0, 2)));
        got.delete();
        keys = 16'h0001 << 9;
        frames(5);
        check("p6_count", got.size(), 1);
        align(20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_col", col_n, 4'b1110);
        check("rst_out", {key_valid, key_held, key_multi, digits}, '0);
        got.delete();
        frames(5);
        check("p6_re_count", got.size(), 1);
        if (got.size() > 0) check("p6_re_code", got[0], 4'h6);
        check("p6_re_digits", digits, 16'h0006);

        // random single-key presses with random release gaps
        for (int k = 0; k < 6; k++) begin
            keys = '0;
            frames(int'($urandom_range(3, 5)));
            repeat ($urandom_range(0, FRAME - 1)) tick();
            keys = 16'h0001 << $urandom_range(0, 15);
            frames(int'($urandom_range(3, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
